// File: rtl/wb_pkg.sv
// Shared write-back definitions: load formats and default datapath widths.
// Also used by the register file and the forwarding unit.
package wb_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int REG_AW_DEF = 3;
  localparam int CNT_W_DEF  = 16;

  localparam logic [1:0] LD_WORD   = 2'b00;
  localparam logic [1:0] LD_BYTE_S = 2'b01;
  localparam logic [1:0] LD_BYTE_U = 2'b10;

endpackage

// File: rtl/wb_stage_reg_if.sv
// Memory-stage to write-back bundle plus register-file write port.
// slave = WB stage, master = upstream stage / register file side.
interface wb_stage_reg_if
  import wb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_AW = REG_AW_DEF,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int SEL_W  = $clog2(DATA_W / 8)
) ();

  logic              stall;
  logic              flush;
  logic              mem_valid;
  logic              mem_reg_we;
  logic [REG_AW-1:0] mem_rd;
  logic              mem_to_reg;
  logic [1:0]        mem_ld_mode;
  logic [SEL_W-1:0]  mem_byte_sel;
  logic [DATA_W-1:0] mem_alu_res;
  logic [DATA_W-1:0] mem_ld_data;
  logic              wb_valid;
  logic              wb_we;
  logic [REG_AW-1:0] wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic [CNT_W-1:0]  retired;

  modport master (
    output stall, flush,
    output mem_valid, mem_reg_we, mem_rd,
    output mem_to_reg, mem_ld_mode, mem_byte_sel,
    output mem_alu_res, mem_ld_data,
    input  wb_valid, wb_we, wb_rd, wb_data, retired
  );

  modport slave (
    input  stall, flush,
    input  mem_valid, mem_reg_we, mem_rd,
    input  mem_to_reg, mem_ld_mode, mem_byte_sel,
    input  mem_alu_res, mem_ld_data,
    output wb_valid, wb_we, wb_rd, wb_data, retired
  );

endinterface

// File: rtl/wb_stage_reg_load_align.sv
// Load formatter: picks a byte lane and sign/zero-extends it,
// or passes the full word through.
module load_align
  import wb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int SEL_W  = $clog2(DATA_W / 8)
) (
  input  logic [DATA_W-1:0] raw,
  input  logic [1:0]        mode,
  input  logic [SEL_W-1:0]  byte_sel,
  output logic [DATA_W-1:0] data
);

  logic [7:0] lane;

  assign lane = raw[{byte_sel, 3'b000} +: 8];

  // Reserved mode 2'b11 falls through to the word path.
  always_comb begin
    data = raw;
    unique case (1'b1)
      (mode == LD_BYTE_S):
        data = {{(DATA_W-8){lane[7]}}, lane};
      (mode == LD_BYTE_U):
        data = {{(DATA_W-8){1'b0}}, lane};
      default:
        data = raw;
    endcase
  end

endmodule

// File: rtl/wb_stage_reg.sv
// Write-back pipeline register: result select, load alignment,
// stall/flush handling and retired-instruction counter.
module wb_stage_reg
  import wb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_AW = REG_AW_DEF,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int SEL_W  = $clog2(DATA_W / 8)
) (
  input  logic           clk,
  input  logic           reset,
  wb_stage_reg_if.slave  bus
);

  logic [DATA_W-1:0] ld_fmt;
  logic [DATA_W-1:0] sel_val;
  logic              we_nxt;

  logic              valid_q;
  logic              we_q;
  logic [REG_AW-1:0] rd_q;
  logic [DATA_W-1:0] data_q;
  logic [CNT_W-1:0]  cnt_q;

  load_align #(
    .DATA_W (DATA_W),
    .SEL_W  (SEL_W)
  ) u_align (
    .raw      (bus.mem_ld_data),
    .mode     (bus.mem_ld_mode),
    .byte_sel (bus.mem_byte_sel),
    .data     (ld_fmt)
  );

  assign sel_val = bus.mem_to_reg ? ld_fmt
                                  : bus.mem_alu_res;

  // r0 is hard-wired to zero, so never write it.
  assign we_nxt = bus.mem_valid & bus.mem_reg_we
                & (bus.mem_rd != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      we_q    <= 1'b0;
      rd_q    <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else if (bus.flush) begin
      valid_q <= 1'b0;
      we_q    <= 1'b0;
      rd_q    <= '0;
      data_q  <= '0;
    end else if (!bus.stall) begin
      valid_q <= bus.mem_valid;
      we_q    <= we_nxt;
      rd_q    <= bus.mem_rd;
      data_q  <= sel_val;
      if (bus.mem_valid)
        cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus.wb_valid = valid_q;
  assign bus.wb_we    = we_q;
  assign bus.wb_rd    = rd_q;
  assign bus.wb_data  = data_q;
  assign bus.retired  = cnt_q;

endmodule

// File: tb/tb_wb_stage_reg.sv
// Directed bench for wb_stage_reg with a 4-bit retired counter
// so that counter wrap is reachable.
module tb_wb_stage_reg;
  import wb_pkg::*;

  localparam int DW = 16;
  localparam int AW = 3;
  localparam int CW = 4;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_err;

  wb_stage_reg_if #(
    .DATA_W (DW), .REG_AW (AW), .CNT_W (CW)
  ) bus ();

  wb_stage_reg #(
    .DATA_W (DW), .REG_AW (AW), .CNT_W (CW)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, obs, exp);
    end
  endtask

  task automatic drv(input logic v, input logic we,
                     input logic [2:0] rd, input logic m2r,
                     input logic [1:0] mode, input logic sel,
                     input logic [15:0] alu,
                     input logic [15:0] ld);
    bus.mem_valid    = v;
    bus.mem_reg_we   = we;
    bus.mem_rd       = rd;
    bus.mem_to_reg   = m2r;
    bus.mem_ld_mode  = mode;
    bus.mem_byte_sel = sel;
    bus.mem_alu_res  = alu;
    bus.mem_ld_data  = ld;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag,
                         input logic v, input logic we,
                         input logic [2:0] rd,
                         input logic [15:0] d,
                         input logic [3:0] cnt);
    chk({tag, ".valid"}, 32'(bus.wb_valid), 32'(v));
    chk({tag, ".we"},    32'(bus.wb_we),    32'(we));
    chk({tag, ".rd"},    32'(bus.wb_rd),    32'(rd));
    chk({tag, ".data"},  32'(bus.wb_data),  32'(d));
    chk({tag, ".ret"},   32'(bus.retired),  32'(cnt));
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    reset = 1'b1;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    drv(1, 1, 3'd6, 0, LD_WORD, 0, 16'hBEEF, 16'h0);
    step();
    step();
    chk_all("rst", 0, 0, 3'd0, 16'h0, 4'd0);
    reset = 1'b0;

    drv(1, 1, 3'd3, 0, LD_WORD, 0, 16'h1234, 16'hA57F);
    step();
    chk_all("alu", 1, 1, 3'd3, 16'h1234, 4'd1);

    drv(1, 1, 3'd5, 1, LD_BYTE_S, 1, 16'h0, 16'hA57F);
    step();
    chk_all("bs1", 1, 1, 3'd5, 16'hFFA5, 4'd2);
    drv(1, 1, 3'd5, 1, LD_BYTE_U, 1, 16'h0, 16'hA57F);
    step();
    chk("bu1", 32'(bus.wb_data), 32'h00A5);
    drv(1, 1, 3'd5, 1, LD_BYTE_S, 0, 16'h0, 16'hA57F);
    step();
    chk("bs0", 32'(bus.wb_data), 32'h007F);
    drv(1, 1, 3'd5, 1, LD_WORD, 1, 16'h0, 16'hA57F);
    step();
    chk("word", 32'(bus.wb_data), 32'hA57F);
    drv(1, 1, 3'd5, 1, 2'b11, 1, 16'h0, 16'hA57F);
    step();
    chk_all("rsv", 1, 1, 3'd5, 16'hA57F, 4'd6);

    drv(1, 1, 3'd0, 0, LD_WORD, 0, 16'h7777, 16'h0);
    step();
    chk_all("r0", 1, 0, 3'd0, 16'h7777, 4'd7);

    drv(0, 1, 3'd4, 0, LD_WORD, 0, 16'h4444, 16'h0);
    step();
    chk("inv.valid", 32'(bus.wb_valid), 32'd0);
    chk("inv.we", 32'(bus.wb_we), 32'd0);
    chk("inv.ret", 32'(bus.retired), 32'd7);

    drv(1, 1, 3'd2, 0, LD_WORD, 0, 16'h1111, 16'h0);
    step();
    chk_all("pre", 1, 1, 3'd2, 16'h1111, 4'd8);
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drv(1, 1, 3'(i + 5), 0, LD_WORD, 0,
          16'h2222 + 16'(i), 16'h0);
      step();
      chk_all("stall", 1, 1, 3'd2, 16'h1111, 4'd8);
    end
    bus.stall = 1'b0;
    drv(1, 1, 3'd4, 0, LD_WORD, 0, 16'h5555, 16'h0);
    step();
    chk_all("rel", 1, 1, 3'd4, 16'h5555, 4'd9);

    bus.stall = 1'b1;
    bus.flush = 1'b1;
    drv(1, 1, 3'd1, 0, LD_WORD, 0, 16'h6666, 16'h0);
    step();
    chk_all("flush", 0, 0, 3'd0, 16'h0, 4'd9);
    bus.flush = 1'b0;
    bus.stall = 1'b0;
    step();
    chk_all("adv", 1, 1, 3'd1, 16'h6666, 4'd10);

    bus.stall = 1'b1;
    reset = 1'b1;
    step();
    chk_all("rst2", 0, 0, 3'd0, 16'h0, 4'd0);
    reset = 1'b0;
    bus.stall = 1'b0;

    drv(1, 1, 3'd7, 0, LD_WORD, 0, 16'h0F0F, 16'h0);
    for (int i = 1; i <= 16; i++) begin
      step();
      if (i == 1)
        chk_all("first", 1, 1, 3'd7, 16'h0F0F, 4'd1);
      if (i == 15)
        chk("cnt15", 32'(bus.retired), 32'd15);
    end
    chk("wrap", 32'(bus.retired), 32'd0);
    step();
    chk("wrap1", 32'(bus.retired), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: run did not finish, expected end");
    $fatal(1);
  end

endmodule

// File: doc/wb_stage_reg.md
# wb_stage_reg

Parametrised write-back pipeline stage for the 16-bit MIPS core, sitting between the data-memory stage and the register file. It registers the memory-stage result with one cycle of latency. It selects between the ALU result and load data, aligns and extends byte loads, and honours stall and flush from the stall-control unit. It drives the register-file write port, mirrors that port as a forwarding source, and keeps a retired-instruction counter.

## Interface
Parameters:
- DATA_W, 16, datapath width; must be a multiple of 8, ≥ 16
- REG_AW, 3, register-address width (2^REG_AW registers; register 0 hard-wired to zero)
- CNT_W, 16, retired-instruction counter width

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; one clock, synchronous reset, active-high as fixed
- stall  in  1  hold all WB state this cycle
- flush  in  1  insert bubble this cycle; has priority over stall
- mem_valid  in  1  memory-stage slot holds a real instruction
- mem_reg_we  in  1  instruction writes a register
- mem_rd  in  REG_AW  destination register
- mem_to_reg  in  1  0 = ALU result, 1 = load data
- mem_ld_mode  in  2  load format: WORD, BYTE_S, BYTE_U
- mem_byte_sel  in  log2(DATA_W/8)  byte lane for byte loads
- mem_alu_res  in  DATA_W  ALU result
- mem_ld_data  in  DATA_W  raw data-memory word
- wb_valid  out  1  WB slot holds a real instruction
- wb_we  out  1  register-file write enable
- wb_rd  out  REG_AW  register-file write address
- wb_data  out  DATA_W  register-file write data; also the forwarding value
- retired  out  CNT_W  count of instructions that entered WB

## Operation
- Selected value is mem_alu_res when mem_to_reg=0. When mem_to_reg=1, it is the load data formatted by mem_ld_mode:
  - WORD: mem_ld_data unchanged.
  - BYTE_S: lane mem_byte_sel (lane 0 = bits 7:0) sign-extended to DATA_W.
  - BYTE_U: the same lane zero-extended.
  - Reserved mode 2'b11 behaves as WORD.
- Update priority per rising edge: reset > flush > stall > advance.
  - reset: wb_valid=0, wb_we=0, wb_rd=0, wb_data=0, retired=0.
  - flush: wb_valid=0 and wb_we=0. wb_rd and wb_data are set to 0. retired is unchanged.
  - stall (flush=0): all outputs and retired hold their values. Inputs are ignored.
  - advance:
    - wb_valid ← mem_valid.
    - wb_we ← mem_valid & mem_reg_we & (mem_rd≠0).
    - wb_rd ← mem_rd.
    - wb_data ← selected value.
    - retired ← retired+1 if mem_valid, wrapping from 2^CNT_W−1 to 0.
- A write to register 0 never asserts wb_we. wb_valid still asserts and retired still counts.
- When mem_valid=0 on advance, wb_we=0. wb_rd and wb_data still capture the inputs; the contents are don't-care for checking but must be deterministic.

## Timing
- Latency is 1 cycle: values presented at edge N appear on outputs after edge N, and the register file writes them at edge N+1.
- All outputs are registers. There is no combinational path from inputs to outputs.
- Stall held for k cycles: outputs are frozen for k cycles and advance on the first edge with stall=0. wb_we stays asserted while frozen, so a repeated register write of the same data is permitted.
- flush and stall asserted together: flush wins.
- reset asserted mid-stream: outputs are zero after that edge regardless of stall or flush. The first advance after reset is deasserted captures normally.
- Counter wrap is silent; there is no overflow flag.

## Structure
- Shared package wb_pkg:
  - load-mode constants LD_WORD=2'b00, LD_BYTE_S=2'b01, LD_BYTE_U=2'b10;
  - default DATA_W, REG_AW and CNT_W values, shared with the register file and the forwarding unit.
- Sub-module load_align: purely combinational. Inputs are raw data, mode and byte_sel; output is the formatted DATA_W value. Instantiated once ahead of the mem_to_reg mux.
- Pipeline register and counter are in the top module.

## Test plan
- Reset, then ALU op: mem_valid=1, mem_reg_we=1, mem_rd=3, mem_to_reg=0, mem_alu_res=16'h1234 → one edge later wb_we=1, wb_rd=3, wb_data=16'h1234, retired=1.
- Loads with mem_ld_data=16'hA57F:
  - BYTE_S lane 1 → wb_data=16'hFFA5.
  - BYTE_U lane 1 → wb_data=16'h00A5.
  - BYTE_S lane 0 → wb_data=16'h007F.
  - WORD → wb_data=16'hA57F.
- Write to r0: mem_rd=0, mem_reg_we=1, mem_valid=1 → wb_valid=1, wb_we=0, retired increments.
- Stall for 3 cycles while inputs change, then release → outputs are frozen for 3 cycles, then show the input present at the release edge. retired increments once, not four times.
- flush and stall asserted together with a valid input → wb_valid=0, wb_we=0, wb_data=0, retired unchanged. reset asserted while stall=1 → all outputs are 0 after the edge.
- Counter wrap with CNT_W=4: 16 valid advances from reset → retired=0. The 17th → retired=1.
